// File: rtl/alu_seq_mult.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_seq_mult: multi-cycle radix-2 Booth signed multiplier, valid/ready |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module alu_seq_mult #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         frac,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         ovf
);

  localparam int                c_cnt_w     = (N > 2) ? $clog2(N) : 1;
  localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [N-1:0]         r_a;
  logic                 r_frac;
  logic [N:0]           r_hi;
  logic [N-1:0]         r_lo;
  logic                 r_qm1;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [N-1:0]         r_result;
  logic                 r_ovf;

  logic [N:0]           w_a_ext;
  logic [N:0]           w_sum;
  logic [2*N-1:0]       w_prod;
  logic [N-1:0]         w_res_nxt;
  logic                 w_ovf_nxt;

  // Upper accumulator half is one bit wider so subtracting the most negative a cannot overflow.
  assign w_a_ext = {r_a[N-1], r_a};

  always_comb begin
    w_sum = r_hi;
    case ({r_qm1, r_lo[0]})
      2'b10:   w_sum = r_hi + w_a_ext;
      2'b01:   w_sum = r_hi - w_a_ext;
      default: w_sum = r_hi;
    endcase
  end

  // Product as it will stand after this step's arithmetic shift.
  assign w_prod = {w_sum, r_lo[N-1:1]};

  always_comb begin
    if (r_frac) begin
      w_res_nxt = w_prod[2*N-2:N-1];
      w_ovf_nxt = w_prod[2*N-1] ^ w_prod[2*N-2];
    end else begin
      w_res_nxt = w_prod[N-1:0];
      w_ovf_nxt = !((&w_prod[2*N-1:N-1]) || !(|w_prod[2*N-1:N-1]));
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_frac   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_qm1    <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_frac  <= frac;
            r_hi    <= '0;
            r_lo    <= b;
            r_qm1   <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_hi  <= {w_sum[N], w_sum[N:1]};
          r_lo  <= {w_sum[0], r_lo[N-1:1]};
          r_qm1 <= r_lo[0];
          r_cnt <= r_cnt + c_cnt_w'(1);
          if (r_cnt == c_last_step) begin
            r_result <= w_res_nxt;
            r_ovf    <= w_ovf_nxt;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && nReset;
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_mult.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_alu_seq_mult: directed and random checks of alu_seq_mult           |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_alu_seq_mult;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         nReset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         frac;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         ovf;

  int vectors     = 0;
  int miscompares = 0;

  alu_seq_mult #(.N(N)) dut (
    .clk      (clk),
    .nReset   (nReset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .frac     (frac),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: full integer product, then scale or truncate; ovf when the selected value leaves n-bit signed range.
  function automatic logic [N:0] model(input logic f, input logic [N-1:0] x, input logic [N-1:0] y);
    int p;
    int r;
    logic v;
    p = int'($signed(x)) * int'($signed(y));
    r = f ? (p >>> (N - 1)) : p;
    v = (r > (2 ** (N - 1)) - 1) || (r < -(2 ** (N - 1)));
    return {v, r[N-1:0]};
  endfunction

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!in_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(N));
  endtask

  task automatic do_op(input logic f, input logic [N-1:0] x, input logic [N-1:0] y,
                       input int hold, input bit pre_ready, input string tag);
    logic [N:0] exp;
    exp = model(f, x, y);
    wait_ready(tag);
    in_valid = 1'b1;
    frac     = f;
    a        = x;
    b        = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = N'($urandom);
    b        = N'($urandom);
    frac     = 1'($urandom);
    if (pre_ready) out_ready = 1'b1;
    wait_valid(tag);
    check({tag, "/result"}, 32'(result), 32'(exp[N-1:0]));
    check({tag, "/ovf"}, 32'(ovf), 32'(exp[N]));
    if (!pre_ready) begin
      repeat (hold) begin
        @(posedge clk); #1;
        check({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
        check({tag, "/hold_result"}, 32'(result), 32'(exp[N-1:0]));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check({tag, "/release"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    nReset    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    frac      = 1'b0;

    #2;
    check("rst/in_ready", 32'(in_ready), 32'd0);
    check("rst/out_valid", 32'(out_valid), 32'd0);
    check("rst/result", 32'(result), 32'd0);
    check("rst/ovf", 32'(ovf), 32'd0);
    #10;
    nReset = 1'b1;
    #1;
    check("rst/idle_ready", 32'(in_ready), 32'd1);

    // Directed operand pairs with literal expected values
    do_op(1'b1, 8'h60, 8'd8,   1, 1'b0, "q075x8");
    check("q075x8/lit", 32'(result), 32'd6);
    do_op(1'b1, 8'hC0, 8'd8,   2, 1'b0, "qm05x8");
    check("qm05x8/lit", 32'(result), 32'hFC);
    do_op(1'b1, 8'h40, 8'd16,  0, 1'b1, "q05x16");
    check("q05x16/lit", 32'(result), 32'd8);
    do_op(1'b0, 8'd3,  8'hEC,  1, 1'b0, "i3xm20");
    check("i3xm20/lit", 32'(result), 32'hC4);
    do_op(1'b0, 8'd16, 8'd16,  1, 1'b0, "i16x16");
    check("i16x16/lit_ovf", 32'(ovf), 32'd1);
    do_op(1'b1, 8'h80, 8'h80,  1, 1'b0, "qmin");
    check("qmin/lit_res", 32'(result), 32'h80);
    check("qmin/lit_ovf", 32'(ovf), 32'd1);

    // Back-pressure with a competing request held on in_valid
    wait_ready("bp");
    in_valid = 1'b1; frac = 1'b1; a = 8'h60; b = 8'd8;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid("bp");
    in_valid = 1'b1; frac = 1'b0; a = 8'd3; b = 8'hEC;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp/valid", 32'(out_valid), 32'd1);
      check("bp/result", 32'(result), 32'd6);
      check("bp/in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp/idle_valid", 32'(out_valid), 32'd0);
    check("bp/idle_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp/accepted", 32'(in_ready), 32'd0);
    wait_valid("bp2");
    check("bp2/result", 32'(result), 32'hC4);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Asynchronous reset during the fourth BUSY cycle
    do_op(1'b0, 8'd100, 8'd3, 0, 1'b0, "prerst");
    wait_ready("arst");
    in_valid = 1'b1; frac = 1'b1; a = 8'h40; b = 8'd16;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    nReset = 1'b0;
    #1;
    check("arst/out_valid", 32'(out_valid), 32'd0);
    check("arst/result", 32'(result), 32'd0);
    check("arst/ovf", 32'(ovf), 32'd0);
    check("arst/in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #4;
    nReset = 1'b1;
    #1;
    check("arst/idle_ready", 32'(in_ready), 32'd1);
    repeat (12) begin
      @(posedge clk); #1;
      check("arst/no_stale", 32'(out_valid), 32'd0);
    end

    // Random operands against the reference model
    for (int i = 0; i < 1000; i++) begin
      do_op(1'($urandom), N'($urandom), N'($urandom), int'($urandom_range(0, 2)),
            1'($urandom), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq_mult.md
Name: alu_seq_mult

Overview:
- Multi-cycle signed multiplier. It is the responder side of a valid/ready multiply-request interface.
- It serves `RMULT` operations off the combinational ALU path, so the picoMIPS datapath can trade latency for area.
- Operand a is Q0.(n-1) fixed point (e.g. 8'b01100000 = 0.75) or a plain integer. Operand b is always a signed integer.
- Result is bit-compatible with the ALU `RMULT` result when frac=1.
- Sits beside the ALU; the controller stalls on in_ready/out_valid.

Parameters:
- n, `DATA_BUS_SIZE (8), operand/result width in bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- nReset  input  1  asynchronous active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request.
- a  input  n  signed multiplicand; Q0.(n-1) when frac=1, integer when frac=0.
- b  input  n  signed integer multiplier.
- frac  input  1  1: result = (a*b)>>>(n-1); 0: result = low n bits of a*b.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- result  output  n  signed result.
- ovf  output  1  true product does not fit in n signed bits after selection.

Behaviour:
- Reset: clock is one; reset is asynchronous and active-low (nReset).
- nReset low forces, immediately: state IDLE, in_ready=0 while reset asserted, out_valid=0, result=0, ovf=0, step counter=0, product register=0.
- After release, in_ready=1 (IDLE).
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept edge is any edge with in_valid&&in_ready.
  - On accept: latch a, b, frac; clear the 2n+1-bit Booth accumulator {P_hi, b, q-1=0}; counter=0; go BUSY.
  - Inputs are don't-care after the accept edge.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each edge performs one radix-2 Booth step: add a for pair 10, subtract a for pair 01, nothing for 00/11. Then arithmetic right shift of the accumulator by 1. Then counter++.
  - The edge where counter==n-1 performs the last step and goes DONE.
  - Exactly n BUSY edges.
- Result formation:
  - Done on the final BUSY edge from the 2n-bit signed product p.
  - frac=1: result=p[2n-2:n-1], i.e. arithmetic shift right n-1, truncating toward -inf. ovf=1 iff p[2n-1]!=p[2n-2] (only possible for a=b=-2^(n-1)).
  - frac=0: result=p[n-1:0]. ovf=1 iff p[2n-1:n-1] not all equal.
  - Wrap, no saturation.
- DONE:
  - out_valid=1; result and ovf held stable.
  - On an edge with out_ready=1: go IDLE, out_valid drops.
  - out_ready may already be high when DONE is entered; then DONE lasts exactly one cycle.
  - in_valid is ignored in DONE, so there is no overlap of consecutive requests.
- Latency: out_valid rises n edges after the accept edge. Throughput is at most one result per n+2 cycles.
- Back-pressure: result/ovf stay constant for the whole time out_valid=1 && out_ready=0.
- result/ovf keep their last value in IDLE and BUSY. They are only updated on the final BUSY edge.
- Reset mid-BUSY or mid-DONE: operation aborted, result lost, no out_valid pulse afterwards.
- in_valid in BUSY/DONE: not accepted. The requester must hold it until in_ready.
- Operands -2^(n-1): the Booth subtract of the most negative a uses an n+1-bit adder, so there is no intermediate overflow.

Test Plan:
- Reset then frac=1, a=8'b01100000 (0.75), b=8 -> out_valid exactly 8 edges after accept; result=6, ovf=0.
- frac=1, a=8'b11000000 (-0.5), b=8 -> result=8'b11111100 (-4), ovf=0. Then a=8'b01000000 (0.5), b=16 -> result=8, ovf=0.
- frac=0, a=3, b=-20 -> result=-60 (8'hC4), ovf=0. Then a=16, b=16 -> result=0, ovf=1. Then frac=1, a=b=-128 -> result=8'h80, ovf=1.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid and result stable, in_ready=0, an asserted in_valid not accepted. Raise out_ready -> IDLE next edge, then the new request is accepted.
- Assert nReset low at the 4th BUSY cycle, asynchronously between edges -> out_valid/result/ovf go 0 immediately. After release, in_ready=1 and no stale out_valid appears.
- Randomised loop of 1000 frac/a/b combinations against a reference model of (a*b)>>>7 or low byte -> result and ovf match, latency always 8.
